rs_pool_age_ordered: RTL and testbench
======================================

// Module: rs_pool_age_ordered
// PURPOSE
//  Parametrised pool of ENTRIES reservation-station slots between decode and a single execute port.
//  Captures up to NUM_SRC operands per instruction and wakes them from NUM_FWD result buses.
//  Issues the oldest-by-allocation ready entry each cycle, selected with an age matrix.
//  Adds a full-pool flush for mispredict recovery, and an occupancy count.
// PARAMETERS
//  ENTRIES   8                    number of RS slots (2..32)
//  ROB_SIZE  16                   ROB depth; TAG_W = $clog2(ROB_SIZE+1)
//  DATA_W    64                   operand width; operands carried as {rdy, data} = DATA_W+1 bits
//  NUM_SRC   3                    source operands per instruction
//  NUM_FWD   3                    forwarding/commit result buses
//  CMD_W     10                   command field width
// PORTS
//  clk_i          in   1                       sole clock
//  reset_n_i      in   1                       asynchronous, active-low reset
//  flush_i        in   1                       synchronous squash of all entries
//  dec_valid_i    in   1                       allocate request
//  dec_tag_i      in   TAG_W                   destination ROB tag
//  dec_src_tag_i  in   NUM_SRC*TAG_W           producer tag per operand
//  dec_src_i      in   NUM_SRC*(DATA_W+1)      {rdy,data} per operand
//  dec_cmd_i      in   CMD_W                   command
//  stall_o        out  1                       pool full; decode must hold
//  fwd_valid_i    in   NUM_FWD                 bus carries a usable result
//  fwd_tag_i      in   NUM_FWD*TAG_W           result tags
//  fwd_val_i      in   NUM_FWD*(DATA_W+1)      {rdy,data} results
//  iss_stall_i    in   1                       execute cannot accept
//  iss_valid_o    out  1                       an entry is ready
//  iss_src_o      out  NUM_SRC*DATA_W          selected operand data
//  iss_cmd_o      out  CMD_W                   selected command
//  iss_tag_o      out  TAG_W                   selected destination tag
//  occupancy_o    out  $clog2(ENTRIES+1)       valid entry count
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - all entry valid bits 0; age matrix 0.
//    - Outputs: stall_o=0, iss_valid_o=0, iss_* = 0, occupancy_o=0.
//  - Allocation:
//    - stall_o = &valid, combinational from registered state only; a slot freed this cycle is not reusable until next cycle.
//    - dec_valid_i & ~stall_o writes the lowest-index free slot at the clock edge.
//    - dec_valid_i while stall_o is ignored.
//  - Dispatch-cycle wakeup: an operand with rdy=0 whose tag matches a fwd bus in the same cycle is written as the bus value.
//  - Wakeup:
//    - Each cycle, every valid entry's operand with rdy=0 compares against all buses.
//    - A bus matches when fwd_valid_i[b] & tag equal & fwd_val_i[b].rdy; on a match the operand captures data and sets rdy.
//    - Multiple matching buses: lowest index b wins.
//  - Ready: entry valid & all NUM_SRC rdy bits set (registered state). No same-cycle issue of a just-woken operand.
//  - Age matrix:
//    - older[i][j]=1 means i allocated before j.
//    - On alloc of k: row k cleared, column k set for every currently valid entry.
//  - Selection:
//    - Ready entry i is chosen iff no other ready entry j has older[j][i].
//    - Selection is one-hot; iss_* are muxed combinationally from it.
//    - When nothing is ready, iss_valid_o=0 and iss_* = 0.
//  - Issue handshake:
//    - iss_valid_o & ~iss_stall_i frees the chosen entry at the edge.
//    - Under iss_stall_i the selection may change next cycle if an older entry becomes ready.
//  - Simultaneous allocate + issue: both take effect; occupancy is unchanged; the new entry is younger than all survivors.
//  - flush_i: all valid bits cleared next edge and overrides same-cycle allocate and issue; iss_valid_o still reflects current state that cycle.
//  - occupancy_o = popcount(valid), registered-state derived.
//  - Tag 0 is reserved (never a producer); comparisons are exact TAG_W-bit.
// STRUCTURE
//  - rs_pkg: operand_t {logic rdy; logic [DATA_W-1:0] data}, fwd_bus_t {valid, tag, val}, TAG_W helper function.
//  - rs_slot sub-module, one per entry: valid, tag, cmd, operands, wakeup compare, ready output.
//  - Pool top holds alloc priority encoder, age matrix, select, issue mux, counters.
// TESTING
//  1. Reset mid-run:
//     - Stimulus: fill 5 entries, pulse reset_n_i low asynchronously.
//     - Expect: occupancy_o=0, iss_valid_o=0 immediately, stall_o=0.
//  2. Age order:
//     - Stimulus: alloc tags 3,4,5 with src not ready; wake tag 5's operands first, then 3's, in the same cycle (bus0/bus1).
//     - Expect: issue order 3 then 5, despite slot indices.
//  3. Full/stall:
//     - Stimulus: ENTRIES=8, alloc 8 with iss_stall_i=1.
//     - Expect: stall_o=1, 9th alloc dropped, occupancy_o=8.
//     - Stimulus: release stall.
//     - Expect: one issue, stall_o=0 next cycle.
//  4. Dispatch wakeup:
//     - Stimulus: alloc src tag 7 rdy=0 while bus2 carries tag 7 value 0x1_DEAD.
//     - Expect: entry ready next cycle, iss_src_o = 0xDEAD.
//  5. Gated forwarding:
//     - Stimulus: bus1 tag match with fwd_valid_i=0, or with val.rdy=0.
//     - Expect: operand stays not ready.
//  6. Flush:
//     - Stimulus: flush_i coincident with alloc and an accepted issue.
//     - Expect: occupancy_o=0 next cycle and no entry survives.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared operand/bus types and tag-width helper for the age-ordered RS pool.
package rs_pkg;
  localparam int RS_DATA_W   = 64;
  localparam int RS_ROB_SIZE = 16;

  function automatic int tag_width(input int rob_size);
    return $clog2(rob_size + 1);
  endfunction

  typedef struct packed {
    logic                 rdy;
    logic [RS_DATA_W-1:0] data;
  } operand_t;

  typedef struct packed {
    logic                              valid;
    logic [tag_width(RS_ROB_SIZE)-1:0] tag;
    operand_t                          val;
  } fwd_bus_t;
endpackage

// File: rtl/rs_slot.sv
// One reservation-station entry: holds a decoded instruction and wakes its
// operands from the result buses until every operand is ready.
module rs_slot
  import rs_pkg::*;
#(
  parameter int TAG_W   = 5,
  parameter int DATA_W  = 64,
  parameter int NUM_SRC = 3,
  parameter int NUM_FWD = 3,
  parameter int CMD_W   = 10
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           clear_i,
  input  logic                           alloc_i,
  input  logic [TAG_W-1:0]               alloc_tag_i,
  input  logic [CMD_W-1:0]               alloc_cmd_i,
  input  logic [NUM_SRC-1:0][TAG_W-1:0]  alloc_src_tag_i,
  input  logic [NUM_SRC-1:0][DATA_W:0]   alloc_src_i,
  input  logic [NUM_FWD-1:0]             fwd_valid_i,
  input  logic [NUM_FWD-1:0][TAG_W-1:0]  fwd_tag_i,
  input  logic [NUM_FWD-1:0][DATA_W:0]   fwd_val_i,
  output logic                           valid_o,
  output logic                           ready_o,
  output logic [TAG_W-1:0]               tag_o,
  output logic [CMD_W-1:0]               cmd_o,
  output logic [NUM_SRC-1:0][DATA_W-1:0] src_data_o
);
  logic                           valid_q, valid_d;
  logic [TAG_W-1:0]               tag_q, tag_d;
  logic [CMD_W-1:0]               cmd_q, cmd_d;
  logic [NUM_SRC-1:0][TAG_W-1:0]  src_tag_q, src_tag_d;
  logic [NUM_SRC-1:0][DATA_W:0]   src_q, src_d;
  logic [NUM_SRC-1:0]             hit;
  logic [NUM_SRC-1:0][DATA_W-1:0] hit_data;
  logic [NUM_SRC-1:0]             rdy_bits;

  always_comb begin
    valid_d   = valid_q;
    tag_d     = tag_q;
    cmd_d     = cmd_q;
    src_tag_d = src_tag_q;
    src_d     = src_q;
    hit       = '0;
    hit_data  = '0;
    if (alloc_i) begin
      valid_d   = 1'b1;
      tag_d     = alloc_tag_i;
      cmd_d     = alloc_cmd_i;
      src_tag_d = alloc_src_tag_i;
      src_d     = alloc_src_i;
    end
    for (int s = 0; s < NUM_SRC; s++) begin
      // Scanning from the top bus down leaves the lowest matching bus in hit_data.
      for (int b = NUM_FWD - 1; b >= 0; b--) begin
        if (fwd_valid_i[b] && fwd_val_i[b][DATA_W] && (fwd_tag_i[b] == src_tag_d[s])) begin
          hit[s]      = 1'b1;
          hit_data[s] = fwd_val_i[b][DATA_W-1:0];
        end
      end
      if ((alloc_i || valid_q) && !src_d[s][DATA_W] && hit[s]) begin
        src_d[s] = {1'b1, hit_data[s]};
      end
    end
    if (clear_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q   <= 1'b0;
      tag_q     <= '0;
      cmd_q     <= '0;
      src_tag_q <= '0;
      src_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      cmd_q     <= cmd_d;
      src_tag_q <= src_tag_d;
      src_q     <= src_d;
    end
  end

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign rdy_bits[gi]   = src_q[gi][DATA_W];
    assign src_data_o[gi] = src_q[gi][DATA_W-1:0];
  end

  assign valid_o = valid_q;
  assign ready_o = valid_q && (&rdy_bits);
  assign tag_o   = tag_q;
  assign cmd_o   = cmd_q;
endmodule

// File: rtl/rs_pool_age_ordered.sv
// Reservation-station pool feeding one execute port; issues the oldest ready
// entry using an allocation-order age matrix.
module rs_pool_age_ordered
  import rs_pkg::*;
#(
  parameter int  ENTRIES  = 8,
  parameter int  ROB_SIZE = RS_ROB_SIZE,
  parameter int  DATA_W   = RS_DATA_W,
  parameter int  NUM_SRC  = 3,
  parameter int  NUM_FWD  = 3,
  parameter int  CMD_W    = 10,
  localparam int TAG_W    = tag_width(ROB_SIZE),
  localparam int OCC_W    = $clog2(ENTRIES + 1)
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          flush_i,
  input  logic                          dec_valid_i,
  input  logic [TAG_W-1:0]              dec_tag_i,
  input  logic [NUM_SRC*TAG_W-1:0]      dec_src_tag_i,
  input  logic [NUM_SRC*(DATA_W+1)-1:0] dec_src_i,
  input  logic [CMD_W-1:0]              dec_cmd_i,
  output logic                          stall_o,
  input  logic [NUM_FWD-1:0]            fwd_valid_i,
  input  logic [NUM_FWD*TAG_W-1:0]      fwd_tag_i,
  input  logic [NUM_FWD*(DATA_W+1)-1:0] fwd_val_i,
  input  logic                          iss_stall_i,
  output logic                          iss_valid_o,
  output logic [NUM_SRC*DATA_W-1:0]     iss_src_o,
  output logic [CMD_W-1:0]              iss_cmd_o,
  output logic [TAG_W-1:0]              iss_tag_o,
  output logic [OCC_W-1:0]              occupancy_o
);
  logic [ENTRIES-1:0]                     valid, ready, sel, alloc_oh, clear;
  logic [ENTRIES-1:0][TAG_W-1:0]          slot_tag;
  logic [ENTRIES-1:0][CMD_W-1:0]          slot_cmd;
  logic [ENTRIES-1:0][NUM_SRC*DATA_W-1:0] slot_src;
  logic [ENTRIES-1:0][ENTRIES-1:0]        older_q, older_d;
  logic                                   alloc_fire, issue_fire;

  assign stall_o     = &valid;
  assign alloc_fire  = dec_valid_i && !stall_o && !flush_i;
  // Isolates the lowest clear bit of the valid vector.
  assign alloc_oh    = ~valid & (valid + ENTRIES'(1));
  assign iss_valid_o = |sel;
  assign issue_fire  = iss_valid_o && !iss_stall_i;

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_slot
    assign clear[gi] = flush_i || (issue_fire && sel[gi]);
    rs_slot #(
      .TAG_W(TAG_W), .DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .CMD_W(CMD_W)
    ) u_slot (
      .clk_i           (clk_i),
      .reset_n_i       (reset_n_i),
      .clear_i         (clear[gi]),
      .alloc_i         (alloc_fire && alloc_oh[gi]),
      .alloc_tag_i     (dec_tag_i),
      .alloc_cmd_i     (dec_cmd_i),
      .alloc_src_tag_i (dec_src_tag_i),
      .alloc_src_i     (dec_src_i),
      .fwd_valid_i     (fwd_valid_i),
      .fwd_tag_i       (fwd_tag_i),
      .fwd_val_i       (fwd_val_i),
      .valid_o         (valid[gi]),
      .ready_o         (ready[gi]),
      .tag_o           (slot_tag[gi]),
      .cmd_o           (slot_cmd[gi]),
      .src_data_o      (slot_src[gi])
    );
  end

  // The new entry gets an empty row and becomes younger than every live entry.
  always_comb begin
    older_d = older_q;
    if (alloc_fire) begin
      for (int j = 0; j < ENTRIES; j++) begin
        if (alloc_oh[j]) older_d[j] = '0;
        else older_d[j] = (older_q[j] & ~alloc_oh) | (alloc_oh & {ENTRIES{valid[j]}});
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) older_q <= '0;
    else            older_q <= older_d;
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      sel[i] = ready[i];
      for (int j = 0; j < ENTRIES; j++) begin
        if (ready[j] && older_q[j][i]) sel[i] = 1'b0;
      end
    end
  end

  always_comb begin
    iss_tag_o   = '0;
    iss_cmd_o   = '0;
    iss_src_o   = '0;
    occupancy_o = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (sel[i]) begin
        iss_tag_o = iss_tag_o | slot_tag[i];
        iss_cmd_o = iss_cmd_o | slot_cmd[i];
        iss_src_o = iss_src_o | slot_src[i];
      end
      occupancy_o = occupancy_o + OCC_W'(valid[i]);
    end
  end
endmodule

// File: tb/tb_rs_pool_age_ordered.sv
// Randomised and directed bench for rs_pool_age_ordered with an in-order queue
// model of the pool and a scoreboard monitor on the issue port.
module tb_rs_pool_age_ordered;
  import rs_pkg::*;
  localparam int ENTRIES = 8, ROB_SIZE = 16, DATA_W = 64, NUM_SRC = 3, NUM_FWD = 3, CMD_W = 10;
  localparam int TAG_W = tag_width(ROB_SIZE);
  localparam int OCC_W = $clog2(ENTRIES + 1);

  logic clk = 1'b0;
  logic reset_n, flush, dec_valid, stall, iss_stall, iss_valid;
  logic [TAG_W-1:0]               dec_tag, iss_tag;
  logic [NUM_SRC-1:0][TAG_W-1:0]  dec_src_tag;
  logic [NUM_SRC-1:0][DATA_W:0]   dec_src;
  logic [CMD_W-1:0]               dec_cmd, iss_cmd;
  logic [NUM_FWD-1:0]             fwd_valid;
  logic [NUM_FWD-1:0][TAG_W-1:0]  fwd_tag;
  logic [NUM_FWD-1:0][DATA_W:0]   fwd_val;
  logic [NUM_SRC-1:0][DATA_W-1:0] iss_src;
  logic [OCC_W-1:0]               occupancy;

  always #5 clk = ~clk;

  rs_pool_age_ordered #(
    .ENTRIES(ENTRIES), .ROB_SIZE(ROB_SIZE), .DATA_W(DATA_W),
    .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .CMD_W(CMD_W)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush),
    .dec_valid_i(dec_valid), .dec_tag_i(dec_tag), .dec_src_tag_i(dec_src_tag),
    .dec_src_i(dec_src), .dec_cmd_i(dec_cmd), .stall_o(stall),
    .fwd_valid_i(fwd_valid), .fwd_tag_i(fwd_tag), .fwd_val_i(fwd_val),
    .iss_stall_i(iss_stall), .iss_valid_o(iss_valid), .iss_src_o(iss_src),
    .iss_cmd_o(iss_cmd), .iss_tag_o(iss_tag), .occupancy_o(occupancy)
  );

  typedef struct packed {
    logic [TAG_W-1:0]               tag;
    logic [CMD_W-1:0]               cmd;
    logic [NUM_SRC-1:0][TAG_W-1:0]  stag;
    logic [NUM_SRC-1:0]             rdy;
    logic [NUM_SRC-1:0][DATA_W-1:0] data;
  } ment_t;
  typedef struct packed {
    logic [TAG_W-1:0]               tag;
    logic [CMD_W-1:0]               cmd;
    logic [NUM_SRC-1:0][DATA_W-1:0] src;
  } iss_t;
  typedef struct packed {
    logic [OCC_W-1:0] occ;
    logic             stall;
    logic             ivalid;
  } stat_t;

  ment_t pool_m[$];
  iss_t  iss_q[$];
  stat_t st_q[$];
  int asserts = 0;
  int fails   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A waiting operand takes the first (lowest) bus that carries its tag with rdy set.
  function automatic ment_t wake(input ment_t e);
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int b = 0; b < NUM_FWD; b++) begin
        if (!e.rdy[s] && fwd_valid[b] && fwd_val[b][DATA_W] && fwd_tag[b] == e.stag[s]) begin
          e.rdy[s]  = 1'b1;
          e.data[s] = fwd_val[b][DATA_W-1:0];
        end
      end
    end
    return e;
  endfunction

  // pool_m is kept in allocation order, so the oldest ready entry is the first ready one.
  task automatic model_eval();
    stat_t st;
    iss_t  is;
    ment_t e;
    ment_t nxt[$];
    int    sel = -1;
    st.occ   = OCC_W'(pool_m.size());
    st.stall = (pool_m.size() == ENTRIES);
    foreach (pool_m[i]) if (sel < 0 && (&pool_m[i].rdy)) sel = i;
    st.ivalid = (sel >= 0);
    st_q.push_back(st);
    if (sel >= 0 && !iss_stall) begin
      is.tag = pool_m[sel].tag;
      is.cmd = pool_m[sel].cmd;
      is.src = pool_m[sel].data;
      iss_q.push_back(is);
    end
    if (flush) begin
      pool_m.delete();
      return;
    end
    foreach (pool_m[i]) if (!(i == sel && !iss_stall)) nxt.push_back(wake(pool_m[i]));
    if (dec_valid && !st.stall) begin
      e.tag  = dec_tag;
      e.cmd  = dec_cmd;
      e.stag = dec_src_tag;
      for (int s = 0; s < NUM_SRC; s++) begin
        e.rdy[s]  = dec_src[s][DATA_W];
        e.data[s] = dec_src[s][DATA_W-1:0];
      end
      nxt.push_back(wake(e));
    end
    pool_m = nxt;
  endtask

  task automatic cycle();
    model_eval();
    @(posedge clk); #1;
    dec_valid = 1'b0;
    fwd_valid = '0;
    flush     = 1'b0;
  endtask

  task automatic put_dec(input int tag, input logic [NUM_SRC-1:0] rdy, input int stag);
    dec_valid = 1'b1;
    dec_tag   = TAG_W'(tag);
    dec_cmd   = CMD_W'($urandom);
    for (int s = 0; s < NUM_SRC; s++) begin
      dec_src_tag[s] = TAG_W'(stag);
      dec_src[s]     = {rdy[s], $urandom, $urandom};
    end
  endtask

  task automatic put_bus(input int b, input logic v, input int tag, input logic rdy, input logic [DATA_W-1:0] d);
    fwd_valid[b] = v;
    fwd_tag[b]   = TAG_W'(tag);
    fwd_val[b]   = {rdy, d};
  endtask

  task automatic async_reset_check();
    dec_valid = 1'b0;
    fwd_valid = '0;
    flush     = 1'b0;
    iss_stall = 1'b1;
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("rst_occupancy", 256'(occupancy), 256'(0));
    check("rst_iss_valid", 256'(iss_valid), 256'(0));
    check("rst_stall", 256'(stall), 256'(0));
    reset_n = 1'b1;
    pool_m.delete();
    @(posedge clk); #1;
  endtask

  // Monitor: per-cycle status plus an issue scoreboard popped on each accepted issue.
  initial begin
    stat_t st;
    iss_t  is;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (st_q.size() > 0) begin
          st = st_q.pop_front();
          check("occupancy", 256'(occupancy), 256'(st.occ));
          check("stall", 256'(stall), 256'(st.stall));
          check("iss_valid", 256'(iss_valid), 256'(st.ivalid));
        end
        if (!iss_valid) check("iss_idle_zero", 256'({iss_tag, iss_cmd, iss_src}), 256'(0));
        if (iss_valid && !iss_stall) begin
          if (iss_q.size() == 0) begin
            asserts++;
            fails++;
            $display("FAIL unexpected_issue: got tag %0d expected no issue", iss_tag);
          end else begin
            is = iss_q.pop_front();
            $display("issue tag=%0d cmd=%0h", iss_tag, iss_cmd);
            check("iss_tag", 256'(iss_tag), 256'(is.tag));
            check("iss_cmd", 256'(iss_cmd), 256'(is.cmd));
            check("iss_src", 256'(iss_src), 256'(is.src));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    flush = 1'b0; dec_valid = 1'b0; iss_stall = 1'b0;
    dec_tag = '0; dec_cmd = '0; dec_src_tag = '0; dec_src = '0;
    fwd_valid = '0; fwd_tag = '0; fwd_val = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    cycle();

    // Reset mid-run with five entries held.
    iss_stall = 1'b1;
    for (int n = 0; n < 5; n++) begin put_dec(n + 1, 3'b111, 1); cycle(); end
    cycle();
    async_reset_check();
    cycle();

    // Age order: tag 5 lands in a lower slot than tag 3 but must issue after it.
    iss_stall = 1'b1;
    put_dec(1, 3'b111, 1); cycle();
    put_dec(3, 3'b000, 9); cycle();
    put_dec(4, 3'b000, 10); cycle();
    iss_stall = 1'b0; cycle();
    put_dec(5, 3'b000, 11); cycle();
    put_bus(0, 1'b1, 11, 1'b1, 64'h55); put_bus(1, 1'b1, 9, 1'b1, 64'h33); cycle();
    repeat (3) cycle();
    put_bus(0, 1'b1, 10, 1'b1, 64'h44); cycle();
    repeat (2) cycle();

    // Full pool: ninth allocate is dropped, one issue frees a slot.
    iss_stall = 1'b1;
    for (int n = 0; n < 9; n++) begin put_dec(n + 1, 3'b111, 1); cycle(); end
    cycle();
    iss_stall = 1'b0;
    put_dec(15, 3'b111, 1); cycle();
    repeat (9) cycle();

    // Dispatch-cycle wakeup, then two matching buses where the lower index wins.
    put_dec(2, 3'b110, 7); put_bus(2, 1'b1, 7, 1'b1, 64'hDEAD); cycle();
    repeat (2) cycle();
    put_dec(3, 3'b000, 8); cycle();
    put_bus(1, 1'b1, 8, 1'b1, 64'h1111); put_bus(2, 1'b1, 8, 1'b1, 64'h2222); cycle();
    repeat (2) cycle();

    // Gated forwarding: invalid bus or bus value without rdy must not wake.
    put_dec(6, 3'b000, 12); cycle();
    put_bus(1, 1'b0, 12, 1'b1, 64'hAAAA); cycle();
    put_bus(1, 1'b1, 12, 1'b0, 64'hBBBB); cycle();
    cycle();
    put_bus(1, 1'b1, 12, 1'b1, 64'hCCCC); cycle();
    repeat (2) cycle();

    // Flush coincident with an allocate and an accepted issue.
    iss_stall = 1'b1;
    put_dec(4, 3'b111, 1); cycle();
    put_dec(5, 3'b111, 1); cycle();
    iss_stall = 1'b0;
    put_dec(6, 3'b111, 1); flush = 1'b1; cycle();
    repeat (2) cycle();

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      iss_stall = ($urandom_range(3) == 0);
      flush     = ($urandom_range(49) == 0);
      if ($urandom_range(1) == 1) begin
        put_dec($urandom_range(16, 1), NUM_SRC'($urandom), 0);
        for (int s = 0; s < NUM_SRC; s++) dec_src_tag[s] = TAG_W'($urandom_range(16, 1));
      end
      for (int b = 0; b < NUM_FWD; b++)
        put_bus(b, 1'($urandom_range(1)), $urandom_range(16, 1), ($urandom_range(7) != 0), {$urandom, $urandom});
      cycle();
    end

    iss_stall = 1'b0;
    flush = 1'b1; cycle();
    repeat (2) cycle();
    check("iss_queue_drained", 256'(iss_q.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
